// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider controller for RV32M DIV/DIVU/REM/REMU
// ports: clk, rst_n (sync, active low), start/op/dividend/divisor request, flush abort,
//        busy (state != IDLE), stall (hold pipeline), valid (1-cycle result pulse), result
// DIV_EARLY_TERM_EN: when defined, |a| < |b| completes from PREP without the CALC loop
module div_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            valid,
  output logic [XLEN-1:0] result
);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  state_t state, state_nxt;
  logic [1:0] op_r;
  logic [XLEN-1:0] a_r, b_r, amag, bmag, rem, quo, quo_fix, rem_fix, sel_prep, sel_fix;
  logic [XLEN:0] trial;
  logic [CNT_W-1:0] cnt;
  logic sgn, q_neg, r_neg, div0, ovf, early, accept;
  assign sgn = ~op_r[0];
  assign amag = (sgn & a_r[XLEN-1]) ? -a_r : a_r;
  assign bmag = (sgn & b_r[XLEN-1]) ? -b_r : b_r;
  assign div0 = b_r == '0;
  assign ovf = sgn & (a_r == MIN) & (b_r == '1);
`ifdef DIV_EARLY_TERM_EN
  assign early = ~div0 & (amag < bmag);
`else
  assign early = 1'b0;
`endif
  // partial remainder needs XLEN+1 bits: the shifted remainder can exceed XLEN bits for large unsigned divisors
  assign trial = {rem, quo[XLEN-1]} - {1'b0, bmag};
  assign quo_fix = q_neg ? -quo : quo;
  assign rem_fix = r_neg ? -rem : rem;
  assign sel_fix = op_r[1] ? rem_fix : quo_fix;
  assign sel_prep = op_r[1] ? (ovf ? '0 : a_r) : (div0 ? '1 : ovf ? MIN : '0);
  assign accept = (state == IDLE) & start & ~flush;
  assign busy = state != IDLE;
  assign valid = (state == DONE) & ~flush;
  assign stall = (start | busy) & ~valid;
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = accept ? PREP : IDLE;
      PREP: state_nxt = flush ? IDLE : (div0 | ovf | early) ? DONE : CALC;
      CALC: state_nxt = flush ? IDLE : (cnt == CNT_W'(XLEN-1)) ? FIX : CALC;
      FIX:  state_nxt = flush ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      op_r <= '0;
      a_r <= '0;
      b_r <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      result <= '0;
    end else begin
      if (accept) begin
        op_r <= op;
        a_r <= dividend;
        b_r <= divisor;
      end
      if (state == PREP) begin
        q_neg <= sgn & (a_r[XLEN-1] ^ b_r[XLEN-1]) & ~div0;
        r_neg <= sgn & a_r[XLEN-1];
        rem <= '0;
        quo <= amag;
        cnt <= '0;
      end
      if (state == CALC) begin
        rem <= trial[XLEN] ? {rem[XLEN-2:0], quo[XLEN-1]} : trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], ~trial[XLEN]};
        cnt <= cnt + CNT_W'(1);
      end
      if (state_nxt == DONE) result <= (state == FIX) ? sel_fix : sel_prep;
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized self-checking bench for div_sequencer against an arithmetic reference model
module tb_div_sequencer;
  localparam int XLEN = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;
  logic clk = 1'b0;
  logic rst_n, start, flush, busy, stall, valid;
  logic [1:0] op;
  logic [31:0] dividend, divisor, result, last_res;
  int checks = 0;
  int errors = 0;
  logic [1:0] d_op [10] = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2, 2'd1, 2'd2, 2'd1};
  logic [31:0] d_a [10] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7,
                            32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB, 32'd3};
  logic [31:0] d_b [10] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd9};
  logic [31:0] d_e [10] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd1,
                            32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'd0};
  div_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dividend(dividend), .divisor(divisor),
    .flush(flush), .busy(busy), .stall(stall), .valid(valid), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == MIN && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : MIN;
    case (o)
      2'd0: return $signed(a) / $signed(b);
      2'd1: return a / b;
      2'd2: return $signed(a) % $signed(b);
      default: return a % b;
    endcase
  endfunction
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_EARLY_TERM_EN
    logic [31:0] ma, mb;
    ma = (!o[0] && a[31]) ? -a : a;
    mb = (!o[0] && b[31]) ? -b : b;
    if (b != 0 && ma < mb) return 2;
`endif
    if (b == 0 || (!o[0] && a == MIN && b == 32'hFFFF_FFFF)) return 2;
    return XLEN + 3;
  endfunction
  task automatic track(input string tag, input logic [31:0] exp, input int lat, input bit hold);
    int first = -1;
    int n = 0;
    for (int c = 1; c <= lat + 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_stall"}, stall, 1);
      end
      if (valid) begin
        n++;
        if (first < 0) first = c;
        chk({tag, "_res"}, result, exp);
        chk({tag, "_vstall"}, stall, 0);
        start = 0;
      end
      if (!hold || c >= lat) start = 0;
      else begin
        op = 2'($urandom);
        dividend = $urandom;
        divisor = $urandom;
      end
    end
    chk({tag, "_lat"}, 32'(first), 32'(lat));
    chk({tag, "_pulses"}, 32'(n), 1);
    last_res = exp;
  endtask
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit hold);
    @(negedge clk);
    start = 1;
    op = o;
    dividend = a;
    divisor = b;
    track($sformatf("op%0d_%h_%h", o, a, b), exp, ref_lat(o, a, b), hold);
  endtask
  initial begin
    logic [1:0] o;
    logic [31:0] a, b;
    int nv;
    rst_n = 0;
    start = 0;
    flush = 0;
    op = 0;
    dividend = 0;
    divisor = 0;
    last_res = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_result", result, 0);
    chk("rst_stall", stall, 0);
    for (int i = 0; i < 10; i++) do_op(d_op[i], d_a[i], d_b[i], d_e[i], i == 9);
    @(negedge clk);
    start = 1;
    op = 1;
    dividend = 1000;
    divisor = 10;
    nv = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 0;
      nv += int'(valid);
      if (c == 10) flush = 1;
    end
    chk("flush_busy", busy, 0);
    chk("flush_novalid", 32'(nv), 0);
    chk("flush_result", result, last_res);
    flush = 0;
    do_op(2'd1, 32'd1000, 32'd10, 32'd100, 0);
    @(negedge clk);
    start = 1;
    op = 0;
    dividend = 32'hFFFF_FF9C;
    divisor = 7;
    repeat (10) begin
      @(negedge clk);
      start = 0;
    end
    rst_n = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_valid", valid, 0);
    rst_n = 1;
    last_res = 0;
    @(negedge clk);
    start = 1;
    flush = 1;
    op = 3;
    dividend = 9;
    divisor = 2;
    @(negedge clk);
    start = 0;
    flush = 0;
    chk("startflush_busy", busy, 0);
    @(negedge clk);
    start = 1;
    op = 1;
    dividend = 5;
    divisor = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("doneflush_pre", valid, 1);
    flush = 1;
    #1 chk("doneflush_valid", valid, 0);
    @(negedge clk);
    flush = 0;
    chk("doneflush_idle", busy, 0);
    @(negedge clk);
    start = 1;
    op = 1;
    dividend = 5;
    divisor = 0;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    chk("b2b_v1", valid, 1);
    chk("b2b_r1", result, 32'hFFFF_FFFF);
    start = 1;
    op = 0;
    dividend = 32'hFFFF_FFF9;
    divisor = 2;
    #1 chk("b2b_vstall", stall, 0);
    @(negedge clk);
    chk("b2b_idle", busy, 0);
    chk("b2b_stall", stall, 1);
    track("b2b", 32'hFFFF_FFFD, ref_lat(2'd0, 32'hFFFF_FFF9, 32'd2), 0);
    repeat (40) begin
      o = 2'($urandom);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: begin a = MIN; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 20);
        3: a = $urandom_range(0, 50);
        4: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      do_op(o, a, b, ref_div(o, a, b), 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller that sequences a radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside the ALU in the execute stage. The main decoder raises `start` for M-extension divide ops.
- Holds the pipeline via `stall` until the result is ready. Handles the RISC-V special cases: divide-by-zero and signed overflow.

Parameters:
- XLEN, 32, operand and result width (power of 2, at least 8).
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a divide; sampled only in IDLE
- op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  input  XLEN  rs1 value, captured on accepted start
- divisor  input  XLEN  rs2 value, captured on accepted start
- flush  input  1  abort the current operation (branch mispredict or trap)
- busy  output  1  high whenever state != IDLE
- stall  output  1  combinational: start & ~valid, OR busy & ~valid
- valid  output  1  one-cycle pulse; result is valid this cycle
- result  output  XLEN  quotient (DIV/DIVU) or remainder (REM/REMU)

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; busy=0, valid=0, result=0; counter=0; all internal registers cleared. Reset wins over start and flush, and aborts an operation in progress.
- State machine: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- IDLE: on start, latch op, dividend and divisor; go to PREP.
- PREP (1 cycle):
  - signed = ~op[0].
  - Form magnitudes |a| and |b|. Record q_neg = signed & (a[XLEN-1] ^ b[XLEN-1]) & (b != 0), and r_neg = signed & a[XLEN-1].
  - Divisor == 0: quotient = all ones, remainder = dividend. Go to DONE.
  - Else if signed and dividend = 0x8000_0000 and divisor = all ones: quotient = 0x8000_0000, remainder = 0. Go to DONE.
  - Otherwise: remainder register = 0, quotient register = |a|, counter = 0. Go to CALC.
- CALC (exactly XLEN cycles), per cycle:
  - {rem,quo} shifted left by 1; trial = rem_shifted - |b| in XLEN+1 bits.
  - If trial is non-negative: rem = trial[XLEN-1:0] and the quotient LSB is 1; else the LSB is 0.
  - Counter increments; on counter == XLEN-1, go to FIX.
- FIX (1 cycle): negate the quotient if q_neg; negate the remainder if r_neg (two's complement, wrap-around). Select per op[1].
- DONE: result register is loaded with the selected value on entry. valid=1 for exactly one cycle, then IDLE. result holds its value until the next DONE.
- Latency, start cycle = 0:
  - Normal: valid in cycle XLEN+3 (35 for XLEN=32).
  - Special case: valid in cycle 2.
- Back-to-back: start may be asserted in the cycle valid is high. It is ignored that cycle and accepted the next cycle, in IDLE.
- start while busy is ignored; the latched operands are not disturbed.
- flush:
  - In PREP, CALC or FIX: next state IDLE; valid never pulses; result unchanged.
  - In DONE: valid is suppressed that cycle.
  - flush together with start in IDLE: start is not accepted.
- stall is low in the valid cycle so the pipeline advances.

Optional Feature:
- Macro DIV_EARLY_TERM_EN.
- Defined: in PREP, if divisor != 0 and |a| < |b| (unsigned), set quotient = 0 and remainder = dividend (original sign), then go to DONE. Latency becomes 2.
- Not defined: such operands take the full CALC path. Results are bit-identical either way; only latency differs.

Test Plan:
- DIVU 100/7 -> valid at cycle 35, result 14; REMU same operands -> result 2.
- DIV -7/2 -> result 0xFFFF_FFFD (-3); REM -7/2 -> result 0xFFFF_FFFF (-1); REM 7/-2 -> 1.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> valid at cycle 2, result 0x8000_0000; REM same operands -> 0.
- DIVU 5/0 -> valid at cycle 2, result 0xFFFF_FFFF; REM -5/0 -> result 0xFFFF_FFFB.
- DIVU 1000/10, flush at cycle 10 -> IDLE at cycle 11, no valid pulse, result unchanged. start at cycle 12 is accepted. Second case: rst_n low mid-CALC -> busy=0 and result=0 next cycle.
- DIVU 3/9 -> result 0: valid at cycle 2 with DIV_EARLY_TERM_EN, cycle 35 without. start held high during busy -> exactly one valid pulse per accepted start.
